barrett_mu_div: RTL and testbench



---
 rtl/barrett_mu_div_if.sv | 28 ++
 rtl/barrett_mu_div.sv | 113 +++++++++++
 tb/tb_barrett_mu_div.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/barrett_mu_div_if.sv
// Request/result bundle for barrett_mu_div: start/done handshake with the
// operands sampled on the accepting edge and results held until the next accept.
interface barrett_mu_div_if #(
   parameter int W = 4
) ();
   // Handshake: start is honoured only while the divider is idle. done pulses
   // for exactly one cycle, and the results are valid from that cycle until
   // the next accepted start.
   logic             start;
   logic             mu_mode;
   logic [2*W-1:0]   dividend;
   logic [W-1:0]     divisor;
   logic             busy;
   logic             done;
   logic [2*W:0]     quotient;
   logic [W-1:0]     remainder;
   logic             div_by_zero;

   modport master (
      output start, mu_mode, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, mu_mode, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/barrett_mu_div.sv
// Restoring divider producing floor(X/N) and X mod N one quotient bit per cycle.
// In mu_mode the dividend is 2^(2W), so the quotient is the Barrett constant mu.
module barrett_mu_div #(
   parameter int W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   barrett_mu_div_if.slave    bus,
   output logic [1:0]         state_o
);

   localparam int CW = $clog2(2*W + 2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [W:0]       part_q;
   logic [2*W:0]     dvd_q;
   logic [W-1:0]     div_q;
   logic [CW-1:0]    cnt_q;

   logic             busy_q;
   logic             done_q;
   logic [2*W:0]     quo_q;
   logic [W-1:0]     rem_q;
   logic             dbz_q;

   logic [W:0]       shifted_d;
   logic [W:0]       part_d;
   logic             qbit_d;

   // Partial remainder stays below 2N, so a W+1-bit compare/subtract cannot overflow.
   always_comb begin
      shifted_d = {part_q[W-1:0], dvd_q[2*W]};
      qbit_d    = (shifted_d >= {1'b0, div_q});
      part_d    = shifted_d;
      if (qbit_d) begin
         part_d = shifted_d - {1'b0, div_q};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         part_q  <= '0;
         dvd_q   <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  div_q  <= bus.divisor;
                  dvd_q  <= bus.mu_mode ? {1'b1, {(2*W){1'b0}}} : {1'b0, bus.dividend};
                  rem_q  <= '0;
                  busy_q <= 1'b1;
                  if (bus.divisor == '0) begin
                     quo_q   <= '1;
                     dbz_q   <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     quo_q   <= '0;
                     dbz_q   <= 1'b0;
                     part_q  <= '0;
                     cnt_q   <= CW'(2*W + 1);
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               part_q <= part_d;
               dvd_q  <= {dvd_q[2*W-1:0], 1'b0};
               quo_q  <= {quo_q[2*W-1:0], qbit_d};
               cnt_q  <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  rem_q   <= part_d[W-1:0];
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quo_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;
   assign state_o         = state_q;

endmodule

// File: tb/tb_barrett_mu_div.sv
// Bench for barrett_mu_div: directed vector table, handshake corner sequences
// and randomized operations checked against an arithmetic reference model.
module tb_barrett_mu_div;

   localparam int W = 4;

   logic       clk;
   logic       rst_n;
   logic [1:0] state_o;
   int         checks;
   int         errors;
   int         done_cnt;

   barrett_mu_div_if #(.W(W)) bus ();

   barrett_mu_div #(.W(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .state_o (state_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.done === 1'b1) done_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       mu;
      logic [7:0] x;
      logic [3:0] n;
      logic [8:0] eq;
      logic [3:0] er;
      logic       edbz;
      int         elat;
   } vec_t;

   vec_t vecs[7];

   logic [13:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: {div_by_zero, remainder, quotient} from plain integer arithmetic.
   function automatic logic [13:0] model(input logic mu, input logic [7:0] x, input logic [3:0] n);
      int unsigned xv;
      xv = mu ? 32'd256 : {24'd0, x};
      if (n == 4'd0) return {1'b1, 4'd0, 9'h1FF};
      return {1'b0, 4'(xv % n), 9'(xv / n)};
   endfunction

   // driver: issue one request, wait for done, report results and latency
   task automatic run_op(input logic mu, input logic [7:0] x, input logic [3:0] n,
                         output logic [8:0] q, output logic [3:0] r, output logic dbz,
                         output int lat);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.mu_mode  = mu;
      bus.dividend = mu ? 8'($urandom) : x;
      bus.divisor  = n;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.mu_mode  = 1'($urandom);
      bus.dividend = 8'($urandom);
      bus.divisor  = 4'($urandom);
      lat = 1;
      chk("busy_rise", 32'(bus.busy), 32'd1);
      while (bus.done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (bus.done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done after %0d cycles, expected done", lat);
      end
      q   = bus.quotient;
      r   = bus.remainder;
      dbz = bus.div_by_zero;
      @(negedge clk);
      chk("busy_fall", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic [8:0]  q;
      logic [3:0]  r;
      logic        dbz;
      int          lat;
      int          d0;
      logic [13:0] e;
      logic        mu;
      logic [7:0]  x;
      logic [3:0]  n;

      checks   = 0;
      errors   = 0;
      done_cnt = 0;

      vecs[0] = '{mu: 1'b0, x: 8'd200, n: 4'd7,  eq: 9'd28,  er: 4'd4, edbz: 1'b0, elat: 10};
      vecs[1] = '{mu: 1'b1, x: 8'd0,   n: 4'd13, eq: 9'd19,  er: 4'd9, edbz: 1'b0, elat: 10};
      vecs[2] = '{mu: 1'b1, x: 8'd0,   n: 4'd1,  eq: 9'd256, er: 4'd0, edbz: 1'b0, elat: 10};
      vecs[3] = '{mu: 1'b0, x: 8'd255, n: 4'd15, eq: 9'd17,  er: 4'd0, edbz: 1'b0, elat: 10};
      vecs[4] = '{mu: 1'b0, x: 8'd0,   n: 4'd9,  eq: 9'd0,   er: 4'd0, edbz: 1'b0, elat: 10};
      vecs[5] = '{mu: 1'b0, x: 8'd100, n: 4'd0,  eq: 9'h1FF, er: 4'd0, edbz: 1'b1, elat: 1};
      vecs[6] = '{mu: 1'b0, x: 8'd10,  n: 4'd3,  eq: 9'd3,   er: 4'd1, edbz: 1'b0, elat: 10};

      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.mu_mode  = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_quotient", 32'(bus.quotient), 32'd0);
      chk("rst_remainder", 32'(bus.remainder), 32'd0);
      chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
      chk("rst_state", 32'(state_o), 32'd0);
      rst_n = 1'b1;

      // directed vector table
      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].mu, vecs[i].x, vecs[i].n, q, r, dbz, lat);
         chk($sformatf("vec%0d_quotient", i), 32'(q), 32'(vecs[i].eq));
         chk($sformatf("vec%0d_remainder", i), 32'(r), 32'(vecs[i].er));
         chk($sformatf("vec%0d_dbz", i), 32'(dbz), 32'(vecs[i].edbz));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].elat));
      end

      // start pulses during RUN and DONE are ignored
      @(negedge clk);
      d0 = done_cnt;
      bus.start = 1'b1; bus.mu_mode = 1'b0; bus.dividend = 8'd200; bus.divisor = 4'd7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd3;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("ign_done_seen", 32'(bus.done), 32'd1);
      bus.start = 1'b1; bus.dividend = 8'd99; bus.divisor = 4'd5;
      @(negedge clk);
      bus.start = 1'b0;
      chk("ign_busy_after_done", 32'(bus.busy), 32'd0);
      repeat (15) @(negedge clk);
      chk("ign_done_count", 32'(done_cnt - d0), 32'd1);
      chk("ign_quotient", 32'(bus.quotient), 32'd28);
      chk("ign_remainder", 32'(bus.remainder), 32'd4);
      chk("ign_state_idle", 32'(state_o), 32'd0);

      // reset in RUN cycle 4 aborts the operation
      @(negedge clk);
      bus.start = 1'b1; bus.mu_mode = 1'b0; bus.dividend = 8'd200; bus.divisor = 4'd7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      d0 = done_cnt;
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_quotient", 32'(bus.quotient), 32'd0);
      chk("abort_remainder", 32'(bus.remainder), 32'd0);
      chk("abort_dbz", 32'(bus.div_by_zero), 32'd0);
      chk("abort_state", 32'(state_o), 32'd0);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      run_op(1'b0, 8'd100, 4'd9, q, r, dbz, lat);
      chk("post_abort_quotient", 32'(q), 32'd11);
      chk("post_abort_remainder", 32'(r), 32'd1);
      chk("post_abort_latency", 32'(lat), 32'd10);

      // randomized operations against the reference model
      for (int k = 0; k < 40; k++) begin
         mu = ($urandom_range(0, 3) == 0);
         x  = 8'($urandom_range(0, 255));
         n  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         exp_q.push_back(model(mu, x, n));
         run_op(mu, x, n, q, r, dbz, lat);
         e = exp_q.pop_front();
         chk($sformatf("rnd%0d_quotient", k), 32'(q), 32'(e[8:0]));
         chk($sformatf("rnd%0d_remainder", k), 32'(r), 32'(e[12:9]));
         chk($sformatf("rnd%0d_dbz", k), 32'(dbz), 32'(e[13]));
         chk($sformatf("rnd%0d_latency", k), 32'(lat), e[13] ? 32'd1 : 32'd10);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
